// File: rtl/reg_readback_tx_if.sv
// Handshake and data bundle between a register readback requester and the
// serial readback transmitter.
interface reg_readback_tx_if;
    logic        start;
    logic [15:0] d;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (output start, output d, input tx, input busy, input done);
    modport slave  (input start, input d, output tx, output busy, output done);
endinterface

// File: rtl/reg_readback_tx.sv
// Serial readback transmitter: frames a captured 16-bit word as
// start, 16 data bits MSB first, even parity, stop.
module reg_readback_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    reg_readback_tx_if.slave   bus
);

    localparam logic [15:0] CYC_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t      state_r;
    logic [15:0] shift_r;
    logic        parity_r;
    logic [3:0]  bit_cnt_r;
    logic [15:0] cyc_cnt_r;
    logic        tx_r;
    logic        busy_r;
    logic        done_r;
    logic        wrap_s;

    function automatic logic even_parity(input logic [15:0] word);
        return ^word;
    endfunction

    assign wrap_s   = (cyc_cnt_r == CYC_LAST);
    assign bus.tx   = tx_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

    // Frame sequencer; all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            shift_r   <= 16'd0;
            parity_r  <= 1'b0;
            bit_cnt_r <= 4'd0;
            cyc_cnt_r <= 16'd0;
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r   <= START;
                        shift_r   <= bus.d;
                        parity_r  <= even_parity(bus.d);
                        bit_cnt_r <= 4'd0;
                        cyc_cnt_r <= 16'd0;
                        tx_r      <= 1'b0;
                        busy_r    <= 1'b1;
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    if (wrap_s) begin
                        state_r   <= DATA;
                        cyc_cnt_r <= 16'd0;
                        bit_cnt_r <= 4'd0;
                        tx_r      <= shift_r[15];
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + 16'd1;
                    end
                end
                DATA: begin
                    if (wrap_s) begin
                        cyc_cnt_r <= 16'd0;
                        if (bit_cnt_r == 4'd15) begin
                            state_r <= PARITY;
                            tx_r    <= parity_r;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            shift_r   <= {shift_r[14:0], 1'b0};
                            tx_r      <= shift_r[14];
                        end
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + 16'd1;
                    end
                end
                PARITY: begin
                    if (wrap_s) begin
                        state_r   <= STOP;
                        cyc_cnt_r <= 16'd0;
                        tx_r      <= 1'b1;
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + 16'd1;
                    end
                end
                STOP: begin
                    // A start seen on the final edge chains straight into the next frame.
                    if (wrap_s) begin
                        done_r    <= 1'b1;
                        cyc_cnt_r <= 16'd0;
                        bit_cnt_r <= 4'd0;
                        if (bus.start) begin
                            state_r  <= START;
                            shift_r  <= bus.d;
                            parity_r <= even_parity(bus.d);
                            tx_r     <= 1'b0;
                            busy_r   <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            tx_r    <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cyc_cnt_r <= 16'd0;
                    bit_cnt_r <= 4'd0;
                    tx_r      <= 1'b1;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_readback_tx.sv
// Scoreboard bench for reg_readback_tx at CLKS_PER_BIT = 4, 1 and 2.
module tb_reg_readback_tx;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    reg_readback_tx_if ia ();
    reg_readback_tx_if ib ();
    reg_readback_tx_if ic ();

    reg_readback_tx #(.CLKS_PER_BIT(4)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
    reg_readback_tx #(.CLKS_PER_BIT(1)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));
    reg_readback_tx #(.CLKS_PER_BIT(2)) dut_c (.clk(clk), .reset(reset), .bus(ic.slave));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected frames: {parity, word}, parity worked out by hand.
    logic [16:0] qa [$];
    logic [16:0] qb [$];
    logic [16:0] qc [$];

    // Per-cycle tx/busy history, newest sample in bit 0.
    logic [75:0] hta = '0, hba = '0;
    logic [75:0] htb = '0, hbb = '0;
    logic [75:0] htc = '0, hbc = '0;
    logic pda = 1'b0, pdb = 1'b0, pdc = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic frame_ok(input logic [75:0] h, input logic [75:0] hb,
                                      input int n, input logic [16:0] e);
        int   len;
        int   b;
        logic want;
        logic ok;
        len = 19 * n;
        ok  = 1'b1;
        for (int j = 0; j < len; j++) begin
            b = j / n;
            if (b == 0)       want = 1'b0;
            else if (b <= 16) want = e[16 - b];
            else if (b == 17) want = e[16];
            else              want = 1'b1;
            if (h[len - 1 - j] !== want) ok = 1'b0;
            if (hb[len - 1 - j] !== 1'b1) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [16:0] decode(input logic [75:0] h, input int n);
        logic [16:0] r;
        int len;
        len = 19 * n;
        r = '0;
        for (int b = 1; b <= 16; b++) r[16 - b] = h[len - 1 - (b * n + n / 2)];
        r[16] = h[len - 1 - (17 * n + n / 2)];
        return r;
    endfunction

    task automatic on_done(input string nm, input int n, input logic [75:0] h,
                           input logic [75:0] hb, input logic have,
                           input logic [16:0] e, input logic pd);
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL %s_unexpected_done actual=done expected=no_done", nm);
        end else if (!frame_ok(h, hb, n, e)) begin
            errors++;
            $display("FAIL %s_frame actual=%h tx_hist=%h busy_hist=%h expected=%h",
                     nm, decode(h, n), h, hb, e);
        end
        chk({nm, "_done_width"}, 32'(pd), 32'd0);
    endtask

    task automatic run_monitor();
        logic        have;
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (ia.done) begin
                have = (qa.size() != 0);
                e    = have ? qa.pop_front() : 17'd0;
                on_done("a", 4, hta, hba, have, e, pda);
            end
            if (ib.done) begin
                have = (qb.size() != 0);
                e    = have ? qb.pop_front() : 17'd0;
                on_done("b", 1, htb, hbb, have, e, pdb);
            end
            if (ic.done) begin
                have = (qc.size() != 0);
                e    = have ? qc.pop_front() : 17'd0;
                on_done("c", 2, htc, hbc, have, e, pdc);
            end
            hta = {hta[74:0], ia.tx}; hba = {hba[74:0], ia.busy}; pda = ia.done;
            htb = {htb[74:0], ib.tx}; hbb = {hbb[74:0], ib.busy}; pdb = ib.done;
            htc = {htc[74:0], ic.tx}; hbc = {hbc[74:0], ic.busy}; pdc = ic.done;
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [15:0] w);
        case (sel)
            0:       begin ia.start = s; ia.d = w; end
            1:       begin ib.start = s; ib.d = w; end
            default: begin ic.start = s; ic.d = w; end
        endcase
    endtask

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return ia.busy;
            1:       return ib.busy;
            default: return ic.busy;
        endcase
    endfunction

    task automatic pulse(input int sel, input logic [15:0] w);
        @(posedge clk); #1 drive(sel, 1'b1, w);
        @(posedge clk); #1 drive(sel, 1'b0, w);
    endtask

    task automatic wait_idle(input int sel, input string nm);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (get_busy(sel) == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_idle_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic run_stimulus();
        logic bad;
        logic seen;
        drive(0, 1'b0, 16'h0000);
        drive(1, 1'b0, 16'h0000);
        drive(2, 1'b0, 16'h0000);

        // Reset acts before any clock edge.
        #1 reset = 1'b1;
        #1;
        chk("rst_tx",   32'(ia.tx),   32'd1);
        chk("rst_busy", 32'(ia.busy), 32'd0);
        chk("rst_done", 32'(ia.done), 32'd0);
        chk("rst_tx_b", 32'(ib.tx),   32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Basic frame, N=4.
        qa.push_back({1'b0, 16'hA5C3});
        pulse(0, 16'hA5C3);
        wait_idle(0, "t1");

        // Parity, N=1.
        qb.push_back({1'b1, 16'h0001});
        pulse(1, 16'h0001);
        wait_idle(1, "t2a");
        qb.push_back({1'b0, 16'h0000});
        pulse(1, 16'h0000);
        wait_idle(1, "t2b");

        // Start while busy is ignored, N=2.
        qc.push_back({1'b0, 16'hFFFF});
        pulse(2, 16'hFFFF);
        repeat (9) @(posedge clk);
        #1 drive(2, 1'b1, 16'h0000);
        @(posedge clk); #1 drive(2, 1'b0, 16'h0000);
        wait_idle(2, "t3");
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (ic.busy) seen = 1'b1;
        end
        chk("t3_no_second_frame", 32'(seen), 32'd0);

        // Back-to-back with start held high, N=2.
        qc.push_back({1'b1, 16'h1234});
        qc.push_back({1'b0, 16'h8001});
        @(posedge clk); #1 drive(2, 1'b1, 16'h1234);
        @(posedge clk); #1 drive(2, 1'b1, 16'h8001);
        @(negedge clk);
        bad = 1'b0;
        for (int k = 1; k <= 76; k++) begin
            @(posedge clk);
            #1 if (k == 40) drive(2, 1'b0, 16'h8001);
            @(negedge clk);
            if (ic.busy !== ((k < 76) ? 1'b1 : 1'b0)) bad = 1'b1;
            if (ic.done !== ((k == 38 || k == 76) ? 1'b1 : 1'b0)) bad = 1'b1;
            if (k == 38 && ic.tx !== 1'b0) bad = 1'b1;
        end
        chk("t4_b2b_busy_done", 32'(bad), 32'd0);

        // Reset during data bit 7, N=4; no frame expected for the aborted one.
        pulse(0, 16'h0000);
        repeat (33) @(posedge clk);
        @(negedge clk);
        chk("t5_tx_bit7", 32'(ia.tx), 32'd0);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_tx",   32'(ia.tx),   32'd1);
        chk("t5_rst_busy", 32'(ia.busy), 32'd0);
        chk("t5_rst_done", 32'(ia.done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        qa.push_back({1'b0, 16'h00FF});
        drive(0, 1'b1, 16'h00FF);
        @(posedge clk); #1 drive(0, 1'b0, 16'h00FF);
        wait_idle(0, "t5");

        // Captured word survives changes on d, N=4.
        qa.push_back({1'b0, 16'hC0DE});
        @(posedge clk); #1 drive(0, 1'b1, 16'hC0DE);
        @(posedge clk); #1 drive(0, 1'b0, 16'h1111);
        wait_idle(0, "t6");

        repeat (5) @(negedge clk);
        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);
        chk("qc_drained", 32'(qc.size()), 32'd0);
    endtask

    initial begin
        fork
            run_monitor();
            run_stimulus();
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
